// File: rtl/prog_fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | prog_fetch_ctrl: program ROM fetch sequencer with 2-entry instr buffer    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module prog_fetch_ctrl #(
  parameter int                ADDR_W       = 16,
  parameter int                DATA_W       = 16,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target
);

  localparam logic [ADDR_W-1:0] c_pc_one = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic [ADDR_W-1:0] buf_pc_q [2];
  logic [ADDR_W-1:0] buf_pc_d [2];
  logic [DATA_W-1:0] buf_instr_q [2];
  logic [DATA_W-1:0] buf_instr_d [2];
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        count_q, count_d;

  logic              w_pop;
  logic              w_push;
  logic              w_issue;
  logic [2:0]        w_occ;

  always_comb begin
    w_pop   = (count_q != 2'd0) & instr_ready;
    // Occupancy counts the in-flight read so the buffer can never overflow.
    w_occ   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, w_pop};
    w_issue = !jump & (w_occ < 3'd2);
    w_push  = inflight_q & !jump;

    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    buf_pc_d      = buf_pc_q;
    buf_instr_d   = buf_instr_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;

    if (jump) begin
      fetch_pc_d = jump_target;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
      count_d    = 2'd0;
    end else begin
      if (w_issue) begin
        fetch_pc_d    = fetch_pc_q + c_pc_one;
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
      end
      if (w_push) begin
        buf_pc_d[wr_ptr_q]    = inflight_pc_q;
        buf_instr_d[wr_ptr_q] = rom_data;
        wr_ptr_d              = ~wr_ptr_q;
      end
      if (w_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q     <= RESET_VECTOR;
      inflight_q     <= 1'b0;
      inflight_pc_q  <= '0;
      buf_pc_q[0]    <= '0;
      buf_pc_q[1]    <= '0;
      buf_instr_q[0] <= '0;
      buf_instr_q[1] <= '0;
      rd_ptr_q       <= 1'b0;
      wr_ptr_q       <= 1'b0;
      count_q        <= 2'd0;
    end else begin
      fetch_pc_q     <= fetch_pc_d;
      inflight_q     <= inflight_d;
      inflight_pc_q  <= inflight_pc_d;
      buf_pc_q       <= buf_pc_d;
      buf_instr_q    <= buf_instr_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
    end
  end

  assign rom_addr    = fetch_pc_q;
  assign instr       = buf_instr_q[rd_ptr_q];
  assign instr_pc    = buf_pc_q[rd_ptr_q];
  assign instr_valid = (count_q != 2'd0);

endmodule
`default_nettype wire

// File: tb/tb_prog_fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_prog_fetch_ctrl: directed self-checking bench for prog_fetch_ctrl      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_prog_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] rom_addr;
  logic [15:0] rom_data;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        jump;
  logic [15:0] jump_target;

  int chk_cnt = 0;
  int err_cnt = 0;

  prog_fetch_ctrl #(
    .ADDR_W      (16),
    .DATA_W      (16),
    .RESET_VECTOR(16'h0000)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .jump       (jump),
    .jump_target(jump_target)
  );

  always #5 clk = ~clk;

  // Synchronous ROM model: ROM[i] = i + 16'h0100
  always_ff @(posedge clk) rom_data <= rom_addr + 16'h0100;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic exp_v, input logic [15:0] exp_pc);
    logic [15:0] exp_instr;
    exp_instr = exp_pc + 16'h0100;
    check({tag, "_valid"}, 32'(instr_valid), 32'(exp_v));
    if (exp_v) begin
      check({tag, "_pc"}, 32'(instr_pc), 32'(exp_pc));
      check({tag, "_instr"}, 32'(instr), 32'(exp_instr));
    end
  endtask

  task automatic stream(input string tag, input logic [15:0] start, input int n);
    logic [15:0] p;
    for (int i = 0; i < n; i++) begin
      p = start + 16'(i);
      check_head(tag, 1'b1, p);
      step();
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) step();
    reset = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_instr"}, 32'(instr), 32'd0);
    check({tag, "_pc"}, 32'(instr_pc), 32'd0);
    check({tag, "_romaddr"}, 32'(rom_addr), 32'd0);
  endtask

  initial begin
    reset       = 1'b1;
    instr_ready = 1'b0;
    jump        = 1'b0;
    jump_target = 16'h0000;

    // 1: reset, first fetch latency, sequential stream
    instr_ready = 1'b1;
    do_reset(3);
    check_reset_state("t1_c0");
    step();
    check_head("t1_c1", 1'b0, 16'h0000);
    check("t1_c1_romaddr", 32'(rom_addr), 32'd1);
    step();
    stream("t1", 16'h0000, 5);

    // 2: backpressure at pc 5
    instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_head("t2_hold", 1'b1, 16'h0005);
      step();
    end
    instr_ready = 1'b1;
    stream("t2", 16'h0005, 4);

    // 3: jump while pc 3 is accepted
    do_reset(1);
    step();
    step();
    stream("t3_pre", 16'h0000, 3);
    check_head("t3_j", 1'b1, 16'h0003);
    jump        = 1'b1;
    jump_target = 16'h0040;
    step();
    jump = 1'b0;
    check_head("t3_j1", 1'b0, 16'h0000);
    step();
    check_head("t3_j2", 1'b0, 16'h0000);
    step();
    stream("t3", 16'h0040, 3);

    // 4: jump with full buffer under backpressure, then back-to-back jumps
    instr_ready = 1'b0;
    do_reset(1);
    step();
    step();
    step();
    step();
    check_head("t4_full", 1'b1, 16'h0000);
    jump        = 1'b1;
    jump_target = 16'h0080;
    step();
    jump = 1'b0;
    check_head("t4_j1", 1'b0, 16'h0000);
    step();
    check_head("t4_j2", 1'b0, 16'h0000);
    step();
    check_head("t4_j3", 1'b1, 16'h0080);
    step();
    check_head("t4_j4", 1'b1, 16'h0080);
    instr_ready = 1'b1;
    stream("t4", 16'h0080, 3);
    jump        = 1'b1;
    jump_target = 16'h0200;
    step();
    jump_target = 16'h0300;
    step();
    jump = 1'b0;
    check_head("t4_jj1", 1'b0, 16'h0000);
    step();
    check_head("t4_jj2", 1'b0, 16'h0000);
    step();
    stream("t4_jj", 16'h0300, 2);

    // 5: address wrap
    jump        = 1'b1;
    jump_target = 16'hFFFE;
    step();
    jump = 1'b0;
    step();
    step();
    stream("t5", 16'hFFFE, 4);

    // 6: reset mid-stream with a read in flight
    reset = 1'b1;
    step();
    check_reset_state("t6_rst");
    reset = 1'b0;
    check_head("t6_c0", 1'b0, 16'h0000);
    step();
    check_head("t6_c1", 1'b0, 16'h0000);
    step();
    stream("t6", 16'h0000, 2);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
